// File: rtl/smag_delta_recon_if.sv
// rtl/smag_delta_recon_if.sv - stream and status bundle for the delta reconstructor
//   in_valid/in_ready/in_load/in_data          : upstream word channel
//   out_valid/out_ready/out_data/out_last/out_clip : reconstructed sample channel
//   err_seq                                    : sticky sequence-error flag
//   slave  : the reconstructor's view
//   master : the environment's view
interface smag_delta_recon_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_load;
  logic [WIDTH:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_clip;
  logic             err_seq;

  modport slave (
    input  in_valid, in_load, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_clip, err_seq
  );

  modport master (
    output in_valid, in_load, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_clip, err_seq
  );
endinterface

// File: rtl/smag_delta_recon.sv
// rtl/smag_delta_recon.sv - sign-magnitude delta decoder with saturation and line framing
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   io  : smag_delta_recon_if.slave (input words, output samples, err_seq)
module smag_delta_recon #(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640
) (
  input  logic                clk,
  input  logic                rst,
  smag_delta_recon_if.slave   io
);
  localparam int CNT_W = $clog2(LINE_LEN + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             valid_q, valid_nxt;
  logic             last_q, last_nxt;
  logic             clip_q, clip_nxt;
  logic             err_q, err_nxt;

  logic             accept;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] delta_val;
  logic             delta_clip;

  assign io.in_ready  = !valid_q || io.out_ready;
  assign accept       = io.in_valid && io.in_ready;
  assign io.out_valid = valid_q;
  // The accumulator is the last emitted sample, so it doubles as out_data.
  assign io.out_data  = acc;
  assign io.out_last  = last_q;
  assign io.out_clip  = clip_q;
  assign io.err_seq   = err_q;

  // Counter is 0 whenever IDLE, so a plain increment yields 1 for the first word.
  assign cnt_inc = cnt + CNT_W'(1);

  // Two extra bits: bit WIDTH+1 flags underflow, bit WIDTH flags overflow.
  // Negative zero subtracts nothing and so needs no special case.
  always_comb begin
    if (io.in_data[WIDTH])
      sum = {2'b00, acc} - {2'b00, io.in_data[WIDTH-1:0]};
    else
      sum = {2'b00, acc} + {2'b00, io.in_data[WIDTH-1:0]};
  end

  always_comb begin
    delta_val  = sum[WIDTH-1:0];
    delta_clip = 1'b0;
    if (sum[WIDTH+1]) begin
      delta_val  = '0;
      delta_clip = 1'b1;
    end else if (sum[WIDTH]) begin
      delta_val  = '1;
      delta_clip = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    last_nxt  = last_q;
    clip_nxt  = clip_q;
    err_nxt   = err_q;
    valid_nxt = valid_q;

    if (accept) begin
      valid_nxt = 1'b1;
    end else if (io.out_ready) begin
      valid_nxt = 1'b0;
    end

    if (accept) begin
      if (io.in_load) begin
        acc_nxt  = io.in_data[WIDTH-1:0];
        clip_nxt = 1'b0;
      end else begin
        acc_nxt  = delta_val;
        clip_nxt = delta_clip;
      end

      // A delta with no base in place is still applied, but flagged.
      if (state == IDLE && !io.in_load) begin
        err_nxt = 1'b1;
      end

      // A mid-line load only reloads acc; framing is purely by count.
      if (cnt_inc == CNT_W'(LINE_LEN)) begin
        last_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        last_nxt  = 1'b0;
        cnt_nxt   = cnt_inc;
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      clip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      valid_q <= valid_nxt;
      last_q  <= last_nxt;
      clip_q  <= clip_nxt;
      err_q   <= err_nxt;
    end
  end
endmodule

// File: tb/tb_smag_delta_recon.sv
// tb/tb_smag_delta_recon.sv - directed vector bench for smag_delta_recon (WIDTH=8, LINE_LEN=4)
module tb_smag_delta_recon;
  localparam int WIDTH    = 8;
  localparam int LINE_LEN = 4;

  typedef struct packed {
    logic       load;
    logic [8:0] data;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_clip;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t tbl [16];

  smag_delta_recon_if #(.WIDTH(WIDTH)) bus ();

  smag_delta_recon #(
    .WIDTH    (WIDTH),
    .LINE_LEN (LINE_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word with out_ready=1, lets it be accepted, then checks the sample.
  task automatic apply_vec(input string name, input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_load  = v.load;
    bus.in_data  = v.data;
    tick();
    chk(name,
        {3'b0, bus.out_valid, bus.in_ready, bus.out_data, bus.out_last, bus.out_clip, bus.err_seq},
        {3'b0, 1'b1, 1'b1, v.exp_data, v.exp_last, v.exp_clip, v.exp_err});
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_load   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // line 1: plain deltas, negative zero on the last sample
    tbl[0]  = '{1'b1, 9'h064, 8'd100, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 9'h014, 8'd120, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 9'h132, 8'd70,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 9'h100, 8'd70,  1'b1, 1'b0, 1'b0};
    // line 2: load with sign bit set, overflow clamp, continue from clamp
    tbl[4]  = '{1'b1, 9'h1FA, 8'd250, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 9'h00A, 8'd255, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 9'h003, 8'd255, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 9'h105, 8'd250, 1'b1, 1'b0, 1'b0};
    // line 3: underflow clamp, continue, mid-line reload ends the line
    tbl[8]  = '{1'b1, 9'h005, 8'd5,   1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 9'h1FF, 8'd0,   1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 9'h007, 8'd7,   1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 9'h032, 8'd50,  1'b1, 1'b0, 1'b0};
    // line 4: range extremes
    tbl[12] = '{1'b1, 9'h100, 8'd0,   1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 9'h101, 8'd0,   1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 9'h0FF, 8'd255, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 9'h000, 8'd255, 1'b1, 1'b0, 1'b0};

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs",
        {11'b0, bus.out_valid, bus.out_data, bus.out_last, bus.out_clip, bus.err_seq},
        16'h0000);
    chk("reset_in_ready", {15'b0, bus.in_ready}, 16'h0001);
    tick();
    rst = 1'b0;

    // four lines back-to-back, one accept per cycle
    for (int i = 0; i < 16; i++) begin
      apply_vec($sformatf("table_%0d", i), tbl[i]);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid_low", {15'b0, bus.out_valid}, 16'h0000);

    // backpressure: in_ready drops, output holds, nothing lost
    apply_vec("stall_base", '{1'b1, 9'h00A, 8'd10, 1'b0, 1'b0, 1'b0});
    bus.out_ready = 1'b0;
    bus.in_load   = 1'b0;
    bus.in_data   = 9'h001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall_hold_%0d", c),
          {6'b0, bus.in_ready, bus.out_valid, bus.out_data},
          {6'b0, 1'b0, 1'b1, 8'd10});
    end
    bus.out_ready = 1'b1;
    apply_vec("stall_rel_0", '{1'b0, 9'h001, 8'd11, 1'b0, 1'b0, 1'b0});
    apply_vec("stall_rel_1", '{1'b0, 9'h002, 8'd13, 1'b0, 1'b0, 1'b0});
    apply_vec("stall_rel_2", '{1'b0, 9'h003, 8'd16, 1'b1, 1'b0, 1'b0});
    bus.in_valid = 1'b0;
    tick();

    // reset mid-line acts without a clock edge
    apply_vec("pre_reset", '{1'b1, 9'h04D, 8'd77, 1'b0, 1'b0, 1'b0});
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset",
        {10'b0, bus.in_ready, bus.out_valid, bus.out_data[3:0]},
        {10'b0, 1'b1, 1'b0, 4'h0});
    chk("async_reset_data", {8'b0, bus.out_data}, 16'h0000);
    tick();
    rst = 1'b0;

    // delta as first word: applied to acc=0, err_seq sticks across lines
    apply_vec("seq_err_0", '{1'b0, 9'h00A, 8'd10, 1'b0, 1'b0, 1'b1});
    apply_vec("seq_err_1", '{1'b0, 9'h001, 8'd11, 1'b0, 1'b0, 1'b1});
    apply_vec("seq_err_2", '{1'b0, 9'h001, 8'd12, 1'b0, 1'b0, 1'b1});
    apply_vec("seq_err_3", '{1'b0, 9'h001, 8'd13, 1'b1, 1'b0, 1'b1});
    apply_vec("seq_err_4", '{1'b1, 9'h007, 8'd7,  1'b0, 1'b0, 1'b1});
    apply_vec("seq_err_5", '{1'b0, 9'h000, 8'd7,  1'b0, 1'b0, 1'b1});
    apply_vec("seq_err_6", '{1'b0, 9'h100, 8'd7,  1'b0, 1'b0, 1'b1});
    apply_vec("seq_err_7", '{1'b0, 9'h001, 8'd8,  1'b1, 1'b0, 1'b1});
    bus.in_valid = 1'b0;
    tick();
    chk("err_sticky_idle", {15'b0, bus.err_seq}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", {15'b0, bus.err_seq}, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
